vga_pattern_gen: RTL and testbench

//  Parametrised VGA timing generator and test-pattern source; successor to vga_test.

---
 rtl/vga_pattern_gen.sv | 127 ++++++++++++
 tb/tb_vga_pattern_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// VGA timing generator with four selectable test patterns.
// All video outputs are registered from the pixel counters (one clock of latency).
module vga_pattern_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0,
   parameter int unsigned R_W      = 5,
   parameter int unsigned G_W      = 6,
   parameter int unsigned B_W      = 5,
   parameter int unsigned CHK_LOG2 = 5,
   localparam int unsigned RGB_W   = R_W + G_W + B_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       mode,
   input  logic [RGB_W-1:0] solid_color,
   output logic             vga_clk,
   output logic             vga_hys,
   output logic             vga_vys,
   output logic [RGB_W-1:0] vga_rgb,
   output logic             vga_nblank,
   output logic             frame_start
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned XW      = $clog2(H_TOTAL);
   localparam int unsigned YW      = $clog2(V_TOTAL);
   // Counters are widened if needed so the checker bit always exists.
   localparam int unsigned HW      = (XW > CHK_LOG2) ? XW : CHK_LOG2 + 1;
   localparam int unsigned VW      = (YW > CHK_LOG2) ? YW : CHK_LOG2 + 1;
   localparam int unsigned BW      = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] BAR_W  = HW'(BW);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic [HW-1:0]    h_cnt_q, h_cnt_d;
   logic [VW-1:0]    v_cnt_q, v_cnt_d;
   logic [1:0]       mode_q;
   logic [RGB_W-1:0] color_q;
   logic             hys_q, vys_q, nblank_q, fs_q;
   logic [RGB_W-1:0] rgb_q;

   logic             h_last, v_last, active, hs_on, vs_on;
   logic [HW-1:0]    bar_idx;
   logic [2:0]       bar;
   logic [RGB_W-1:0] pix;

   assign h_last = (h_cnt_q == H_LAST);
   assign v_last = (v_cnt_q == V_LAST);
   assign active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
   assign hs_on  = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
   assign vs_on  = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);

   always_comb begin
      h_cnt_d = h_last ? '0 : h_cnt_q + HW'(1);
      v_cnt_d = v_cnt_q;
      if (h_last) begin
         v_cnt_d = v_last ? '0 : v_cnt_q + VW'(1);
      end
   end

   // Bar colours follow the inverted bar index bits: G = ~b2, R = ~b1, B = ~b0.
   always_comb begin
      bar_idx = h_cnt_q / BAR_W;
      bar     = (bar_idx > HW'(7)) ? 3'd7 : bar_idx[2:0];
      pix     = '0;
      case (mode_q)
         2'd0:    pix = {{R_W{~bar[1]}}, {G_W{~bar[2]}}, {B_W{~bar[0]}}};
         2'd1:    pix = {RGB_W{h_cnt_q[CHK_LOG2] ^ v_cnt_q[CHK_LOG2]}};
         // Top channel-width bits of the XW-bit x, zero-padded below if x is narrower.
         2'd2:    pix = {R_W'({h_cnt_q[XW-1:0], {R_W{1'b0}}} >> XW),
                         G_W'({h_cnt_q[XW-1:0], {G_W{1'b0}}} >> XW),
                         B_W'({h_cnt_q[XW-1:0], {B_W{1'b0}}} >> XW)};
         default: pix = color_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_q  <= '0;
         v_cnt_q  <= '0;
         mode_q   <= '0;
         color_q  <= '0;
         hys_q    <= ~HS_POL;
         vys_q    <= ~VS_POL;
         rgb_q    <= '0;
         nblank_q <= 1'b0;
         fs_q     <= 1'b0;
      end else begin
         h_cnt_q  <= h_cnt_d;
         v_cnt_q  <= v_cnt_d;
         // Pattern selection only changes on the frame boundary so a frame never tears.
         if (h_last && v_last) begin
            mode_q  <= mode;
            color_q <= solid_color;
         end
         hys_q    <= hs_on ? HS_POL : ~HS_POL;
         vys_q    <= vs_on ? VS_POL : ~VS_POL;
         rgb_q    <= active ? pix : '0;
         nblank_q <= active;
         fs_q     <= (h_cnt_q == '0) && (v_cnt_q == '0);
      end
   end

   assign vga_clk     = ~clk;
   assign vga_hys     = hys_q;
   assign vga_vys     = vys_q;
   assign vga_rgb     = rgb_q;
   assign vga_nblank  = nblank_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomised bench for vga_pattern_gen: two instances (default line timing with a short
// frame, and a tiny grid with active-high syncs) compared each cycle against a pixel model.
module tb_vga_pattern_gen;

   localparam int FA = 800 * 37;
   localparam int FB = 23 * 12;
   localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                        16'hF81F, 16'hF800, 16'h001F, 16'h0000};

   logic        clk, rst_n;
   logic [1:0]  mode;
   logic [15:0] solid;
   logic        a_vclk, a_hys, a_vys, a_nblank, a_fs;
   logic [15:0] a_rgb;
   logic        b_vclk, b_hys, b_vys, b_nblank, b_fs;
   logic [15:0] b_rgb;

   int          n_checks, n_errors;
   int          k;
   logic [1:0]  cm_a, pm_a, cm_b, pm_b;
   logic [15:0] cc_a, pc_a, cc_b, pc_b;
   int          nb_a, hs_a, hs_first_a, fs_last_b;

   vga_pattern_gen #(
      .V_ACTIVE(34), .V_FP(1), .V_SYNC(1), .V_BP(1)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .mode(mode), .solid_color(solid),
      .vga_clk(a_vclk), .vga_hys(a_hys), .vga_vys(a_vys), .vga_rgb(a_rgb),
      .vga_nblank(a_nblank), .frame_start(a_fs)
   );

   vga_pattern_gen #(
      .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b1), .CHK_LOG2(2)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .mode(mode), .solid_color(solid),
      .vga_clk(b_vclk), .vga_hys(b_hys), .vga_vys(b_vys), .vga_rgb(b_rgb),
      .vga_nblank(b_nblank), .frame_start(b_fs)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, k);
      end
   endtask

   function automatic int unsigned top_bits(int unsigned x, int unsigned xw, int unsigned w);
      int unsigned v;
      v = (xw >= w) ? (x >> (xw - w)) : (x << (w - xw));
      return v & ((32'd1 << w) - 1);
   endfunction

   // Expected {hsync, vsync, nblank, frame_start, rgb} after edge kk since reset release.
   function automatic logic [19:0] model(int unsigned kk, int unsigned ha, int unsigned hf,
         int unsigned hs, int unsigned hb, int unsigned va, int unsigned vf, int unsigned vs,
         int unsigned vb, bit hp, bit vp, int unsigned chk, logic [1:0] md, logic [15:0] col);
      int unsigned ht, vt, p, x, y, bar, xw;
      logic        hsy, vsy, act;
      logic [15:0] rgb;
      if (kk == 0) return {~hp, ~vp, 1'b0, 1'b0, 16'h0000};
      ht  = ha + hf + hs + hb;
      vt  = va + vf + vs + vb;
      p   = (kk - 1) % (ht * vt);
      x   = p % ht;
      y   = p / ht;
      hsy = (x >= ha + hf) && (x < ha + hf + hs);
      vsy = (y >= va + vf) && (y < va + vf + vs);
      act = (x < ha) && (y < va);
      rgb = 16'h0000;
      if (act) begin
         case (md)
            2'd0: begin
               bar = x / (ha / 8);
               if (bar > 7) bar = 7;
               rgb = BARS[bar];
            end
            2'd1: rgb = (((x >> chk) ^ (y >> chk)) & 1) != 0 ? 16'hFFFF : 16'h0000;
            2'd2: begin
               xw  = $clog2(ht);
               rgb = 16'((top_bits(x, xw, 5) << 11) | (top_bits(x, xw, 6) << 5)
                         | top_bits(x, xw, 5));
            end
            default: rgb = col;
         endcase
      end
      return {hsy ? hp : ~hp, vsy ? vp : ~vp, act, p == 0, rgb};
   endfunction

   task automatic check_all();
      check("a_out", {12'h0, a_hys, a_vys, a_nblank, a_fs, a_rgb},
            {12'h0, model(k, 640, 16, 96, 48, 34, 1, 1, 1, 1'b0, 1'b0, 5, cm_a, cc_a)});
      check("b_out", {12'h0, b_hys, b_vys, b_nblank, b_fs, b_rgb},
            {12'h0, model(k, 16, 2, 3, 2, 8, 1, 2, 1, 1'b1, 1'b1, 2, cm_b, cc_b)});
      check("vga_clk_high", {30'h0, a_vclk, b_vclk}, 32'h3);
   endtask

   // One clock: note frame-boundary latches, advance the model, then compare.
   task automatic tick();
      if (rst_n && ((k + 1) % FA == 0)) begin pm_a = mode; pc_a = solid; end
      if (rst_n && ((k + 1) % FB == 0)) begin pm_b = mode; pc_b = solid; end
      @(posedge clk);
      if (rst_n) begin
         k++;
      end else begin
         k = 0; cm_a = 0; pm_a = 0; cc_a = 0; pc_a = 0;
         cm_b = 0; pm_b = 0; cc_b = 0; pc_b = 0; fs_last_b = 0;
      end
      if (k > 1 && (k - 1) % FA == 0) begin cm_a = pm_a; cc_a = pc_a; end
      if (k > 1 && (k - 1) % FB == 0) begin cm_b = pm_b; cc_b = pc_b; end
      @(negedge clk);
      check_all();
      if (k >= 1 && k <= 800) begin
         nb_a += int'(a_nblank);
         if (!a_hys) begin
            hs_a++;
            if (hs_first_a == 0) hs_first_a = k;
         end
      end
      if (b_fs) begin
         if (fs_last_b != 0) check("b_fs_period", k - fs_last_b, FB);
         fs_last_b = k;
      end
   endtask

   task automatic run_to_b(input int pix);
      do tick(); while ((k - 1) % FB != pix);
   endtask

   initial begin
      n_checks = 0; n_errors = 0; k = 0;
      nb_a = 0; hs_a = 0; hs_first_a = 0; fs_last_b = 0;
      cm_a = 0; pm_a = 0; cc_a = 0; pc_a = 0; cm_b = 0; pm_b = 0; cc_b = 0; pc_b = 0;
      rst_n = 1'b0; mode = 2'd2; solid = 16'h1234;

      repeat (5) tick();
      check("a_rst_sync", {30'h0, a_hys, a_vys}, 32'h3);
      check("b_rst_sync", {30'h0, b_hys, b_vys}, 32'h0);
      check("a_rst_rgb", a_rgb, 16'h0000);
      check("a_rst_nblank_fs", {30'h0, a_nblank, a_fs}, 32'h0);
      @(posedge clk);
      #1 check("vga_clk_low", {30'h0, a_vclk, b_vclk}, 32'h0);
      @(negedge clk);

      rst_n = 1'b1;
      tick();
      check("a_first_fs", a_fs, 1);
      check("b_first_fs", b_fs, 1);
      check("a_first_nblank", a_nblank, 1);
      check("a_x0_white", a_rgb, 16'hFFFF);
      tick();
      check("a_second_fs", a_fs, 0);

      while (k < FA + 32 * 800 + 33) begin
         if (k >= FA - 100 && k < FA) begin
            mode = 2'd1;
         end else if ($urandom_range(0, 39) == 0) begin
            mode  = 2'($urandom_range(0, 3));
            solid = 16'($urandom);
         end
         tick();
         if (k == 81)  check("a_x80_yellow", a_rgb, 16'hFFE0);
         if (k == 640) check("a_x639_black", a_rgb, 16'h0000);
         if (k == 800) check("a_line_end_blank", a_nblank, 0);
         if (k == 801) begin
            check("a_next_line_nblank", a_nblank, 1);
            check("a_nblank_count", nb_a, 640);
            check("a_hsync_count", hs_a, 96);
            check("a_hsync_start", hs_first_a, 657);
         end
         if (k == FA + 33) check("a_chk_32_0", a_rgb, 16'hFFFF);
         if (k == FA + 32 * 800 + 33) check("a_chk_32_32", a_rgb, 16'h0000);
      end

      // Switch bars -> solid mid-frame on the small grid.
      mode = 2'd0;
      while (k % FB != 0) tick();
      run_to_b(4 * 23);
      mode  = 2'd3;
      solid = 16'hF800;
      run_to_b(5 * 23 + 1);
      check("b_midframe_still_bars", b_rgb, 16'hFFFF);
      run_to_b(0);
      check("b_solid_first", b_rgb, 16'hF800);
      run_to_b(7 * 23 + 15);
      check("b_solid_last", b_rgb, 16'hF800);

      // Asynchronous reset mid-frame.
      repeat (40) tick();
      #2 rst_n = 1'b0;
      #1;
      check("a_async_rst", {12'h0, a_hys, a_vys, a_nblank, a_fs, a_rgb}, {12'h0, 4'b1100, 16'h0});
      check("b_async_rst", {12'h0, b_hys, b_vys, b_nblank, b_fs, b_rgb}, {12'h0, 4'b0000, 16'h0});
      mode = 2'd2;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      check("b_restart_fs", b_fs, 1);
      check("b_restart_mode0", b_rgb, 16'hFFFF);
      check("a_restart_mode0", a_rgb, 16'hFFFF);
      repeat (2 * FB + 10) tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
